mc_ctrl_fsm: RTL and testbench

- Multicycle MIPS main control unit: a Moore-style FSM (Mealy only on mem_ready and zero) sequencing fetch/decode/execute/memory/writeback.
- Generates every datapath select and enable, including the 1-bit 2:1 mux selects (iord, alusrca, regdst, memtoreg) and the PC-source select.
- Sits directly upstream of the datapath muxes, register file, PC and memory interface.

---
 rtl/mc_ctrl_pkg.sv | 70 +++++++
 rtl/mc_ctrl_decode.sv | 93 +++++++++
 rtl/mc_ctrl_fsm.sv | 104 ++++++++++
 tb/tb_mc_ctrl_fsm.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/mc_ctrl_pkg.sv
// ============================================================================
//  Module      : mc_ctrl_pkg
//  Description : State codes, opcode constants, mux-select codes and the
//                control-word type for the multicycle MIPS main control.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package mc_ctrl_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_FETCH    = 4'd1;
  localparam logic [3:0] ST_DECODE   = 4'd2;
  localparam logic [3:0] ST_MEMADR   = 4'd3;
  localparam logic [3:0] ST_MEMRD    = 4'd4;
  localparam logic [3:0] ST_MEMWB    = 4'd5;
  localparam logic [3:0] ST_MEMWR    = 4'd6;
  localparam logic [3:0] ST_RTYPE_EX = 4'd7;
  localparam logic [3:0] ST_RTYPE_WB = 4'd8;
  localparam logic [3:0] ST_ADDI_EX  = 4'd9;
  localparam logic [3:0] ST_ADDI_WB  = 4'd10;
  localparam logic [3:0] ST_BRANCH   = 4'd11;
  localparam logic [3:0] ST_JUMP     = 4'd12;
  localparam logic [3:0] ST_ILLEGAL  = 4'd13;
  localparam logic [3:0] ST_BNE      = 4'd14;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef struct packed {
    logic       pc_en;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       regdst;
    logic       memtoreg;
    logic       reg_write;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic       illegal;
  } ctrl_t;

  function automatic ctrl_t ctrl_none();
    return '0;
  endfunction

endpackage

`default_nettype wire

// File: rtl/mc_ctrl_decode.sv
// ============================================================================
//  Module      : mc_ctrl_decode
//  Description : Combinational map from (state, mem_ready, zero) to the
//                control word. BNE state honoured when MC_CTRL_BNE_EN is set.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_ctrl_decode
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic [STATE_W-1:0] state_i,
  input  logic               mem_ready_i,
  input  logic               zero_i,
  output ctrl_t              ctrl_o
);

  always_comb begin
    ctrl_o = ctrl_none();
    case (state_i)
      ST_FETCH: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.alusrcb  = SRCB_FOUR;
        ctrl_o.aluop    = ALUOP_ADD;
        ctrl_o.pcsource = PCSRC_ALU;
        ctrl_o.ir_write = mem_ready_i;
        ctrl_o.pc_en    = mem_ready_i;
      end
      ST_DECODE: begin
        ctrl_o.alusrcb = SRCB_IMMSH;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      ST_MEMADR, ST_ADDI_EX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_IMM;
        ctrl_o.aluop   = ALUOP_ADD;
      end
      ST_MEMRD: begin
        ctrl_o.mem_read = 1'b1;
        ctrl_o.iord     = 1'b1;
      end
      ST_MEMWB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.memtoreg  = 1'b1;
      end
      ST_MEMWR: begin
        ctrl_o.mem_write = 1'b1;
        ctrl_o.iord      = 1'b1;
      end
      ST_RTYPE_EX: begin
        ctrl_o.alusrca = 1'b1;
        ctrl_o.alusrcb = SRCB_B;
        ctrl_o.aluop   = ALUOP_FUNCT;
      end
      ST_RTYPE_WB: begin
        ctrl_o.reg_write = 1'b1;
        ctrl_o.regdst    = 1'b1;
      end
      ST_ADDI_WB: begin
        ctrl_o.reg_write = 1'b1;
      end
      ST_BRANCH: begin
        ctrl_o.alusrca  = 1'b1;
        ctrl_o.alusrcb  = SRCB_B;
        ctrl_o.aluop    = ALUOP_SUB;
        ctrl_o.pcsource = PCSRC_ALUOUT;
        ctrl_o.pc_en    = zero_i;
      end
`ifdef MC_CTRL_BNE_EN
      ST_BNE: begin
        ctrl_o.alusrca  = 1'b1;
        ctrl_o.alusrcb  = SRCB_B;
        ctrl_o.aluop    = ALUOP_SUB;
        ctrl_o.pcsource = PCSRC_ALUOUT;
        ctrl_o.pc_en    = ~zero_i;
      end
`endif
      ST_JUMP: begin
        ctrl_o.pcsource = PCSRC_JUMP;
        ctrl_o.pc_en    = 1'b1;
      end
      ST_ILLEGAL: begin
        ctrl_o.illegal = 1'b1;
      end
      default: ctrl_o = ctrl_none();
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mc_ctrl_fsm.sv
// ============================================================================
//  Module      : mc_ctrl_fsm
//  Description : Multicycle MIPS main control FSM: state register, next-state
//                logic and reset-gated control outputs. Optional bne support
//                is compiled in with macro MC_CTRL_BNE_EN.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module mc_ctrl_fsm
  import mc_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] opcode,
  input  logic       zero,
  input  logic       mem_ready,
  output logic       pc_en,
  output logic       iord,
  output logic       mem_read,
  output logic       mem_write,
  output logic       ir_write,
  output logic       regdst,
  output logic       memtoreg,
  output logic       reg_write,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       illegal
);

  logic [STATE_W-1:0] state_q;
  logic [STATE_W-1:0] state_d;
  ctrl_t              w_ctrl;
  ctrl_t              w_ctrl_out;

  always_comb begin
    state_d = ST_FETCH;
    case (state_q)
      ST_IDLE:     state_d = ST_FETCH;
      ST_FETCH:    state_d = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: state_d = ST_MEMADR;
          OP_RTYPE:     state_d = ST_RTYPE_EX;
          OP_BEQ:       state_d = ST_BRANCH;
          OP_J:         state_d = ST_JUMP;
          OP_ADDI:      state_d = ST_ADDI_EX;
`ifdef MC_CTRL_BNE_EN
          OP_BNE:       state_d = ST_BNE;
`endif
          default:      state_d = ST_ILLEGAL;
        endcase
      end
      ST_MEMADR:   state_d = (opcode == OP_LW) ? ST_MEMRD : ST_MEMWR;
      ST_MEMRD:    state_d = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWR:    state_d = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_RTYPE_EX: state_d = ST_RTYPE_WB;
      ST_ADDI_EX:  state_d = ST_ADDI_WB;
      // WB, branch, jump, illegal and unreachable codes all resume at FETCH
      default:     state_d = ST_FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  mc_ctrl_decode #(
    .STATE_W     (STATE_W)
  ) u_decode (
    .state_i     (state_q),
    .mem_ready_i (mem_ready),
    .zero_i      (zero),
    .ctrl_o      (w_ctrl)
  );

  // Suppress enables during the reset cycle so an aborted access commits nothing.
  assign w_ctrl_out = rst ? ctrl_none() : w_ctrl;

  assign pc_en     = w_ctrl_out.pc_en;
  assign iord      = w_ctrl_out.iord;
  assign mem_read  = w_ctrl_out.mem_read;
  assign mem_write = w_ctrl_out.mem_write;
  assign ir_write  = w_ctrl_out.ir_write;
  assign regdst    = w_ctrl_out.regdst;
  assign memtoreg  = w_ctrl_out.memtoreg;
  assign reg_write = w_ctrl_out.reg_write;
  assign alusrca   = w_ctrl_out.alusrca;
  assign alusrcb   = w_ctrl_out.alusrcb;
  assign aluop     = w_ctrl_out.aluop;
  assign pcsource  = w_ctrl_out.pcsource;
  assign illegal   = w_ctrl_out.illegal;

endmodule

`default_nettype wire

// File: tb/tb_mc_ctrl_fsm.sv
// ============================================================================
//  Module      : tb_mc_ctrl_fsm
//  Description : Self-checking bench for mc_ctrl_fsm (honours MC_CTRL_BNE_EN).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_mc_ctrl_fsm;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       pc_en, iord, mem_read, mem_write, ir_write, regdst;
  logic       memtoreg, reg_write, alusrca, illegal;
  logic [1:0] alusrcb, aluop, pcsource;

  mc_ctrl_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .pc_en(pc_en), .iord(iord), .mem_read(mem_read), .mem_write(mem_write),
    .ir_write(ir_write), .regdst(regdst), .memtoreg(memtoreg),
    .reg_write(reg_write), .alusrca(alusrca), .alusrcb(alusrcb),
    .aluop(aluop), .pcsource(pcsource), .illegal(illegal)
  );

  always #5 clk = ~clk;

  typedef enum {P_ZERO, P_FETCH, P_DECODE, P_MEMADR, P_MEMRD, P_MEMWB, P_MEMWR,
                P_REX, P_RWB, P_AEX, P_AWB, P_BR, P_BNE, P_JUMP, P_ILL} phase_e;

  int          vectors = 0;
  int          miscompares = 0;
  logic        chk_v = 1'b0;
  logic        lit_v = 1'b0;
  logic [15:0] exp_w = '0;
  logic [15:0] lit_w = '0;
  string       chk_name = "";
  logic [15:0] dut_w;

  // {pc_en,iord,mem_read,mem_write,ir_write,regdst,memtoreg,reg_write,alusrca,alusrcb,aluop,pcsource,illegal}
  assign dut_w = {pc_en, iord, mem_read, mem_write, ir_write, regdst, memtoreg,
                  reg_write, alusrca, alusrcb, aluop, pcsource, illegal};

  // Per-phase control outputs straight from the operation table.
  function automatic logic [15:0] model(input phase_e ph, input logic rdy, input logic z);
    logic pe, io, mr, mw, irw, rd, m2r, rw, sa, il;
    logic [1:0] sb, ao, ps;
    pe = 0; io = 0; mr = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; sa = 0; il = 0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (ph)
      P_FETCH:  begin mr = 1; sb = 2'b01; irw = rdy; pe = rdy; end
      P_DECODE: sb = 2'b11;
      P_MEMADR: begin sa = 1; sb = 2'b10; end
      P_MEMRD:  begin mr = 1; io = 1; end
      P_MEMWB:  begin rw = 1; m2r = 1; end
      P_MEMWR:  begin mw = 1; io = 1; end
      P_REX:    begin sa = 1; ao = 2'b10; end
      P_RWB:    begin rw = 1; rd = 1; end
      P_AEX:    begin sa = 1; sb = 2'b10; end
      P_AWB:    rw = 1;
      P_BR:     begin sa = 1; ao = 2'b01; ps = 2'b01; pe = z; end
      P_BNE:    begin sa = 1; ao = 2'b01; ps = 2'b01; pe = ~z; end
      P_JUMP:   begin ps = 2'b10; pe = 1; end
      P_ILL:    il = 1;
      default:  ;
    endcase
    return {pe, io, mr, mw, irw, rd, m2r, rw, sa, sb, ao, ps, il};
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  always @(negedge clk) begin
    if (chk_v) begin
      vectors++;
      if (dut_w !== exp_w) begin
        miscompares++;
        $display("FAIL %s @%0t: got %h expected %h", chk_name, $time, dut_w, exp_w);
      end
      if (lit_v) begin
        vectors++;
        if (dut_w !== lit_w) begin
          miscompares++;
          $display("FAIL %s_lit @%0t: got %h expected %h", chk_name, $time, dut_w, lit_w);
        end
      end
    end
  end

  task automatic step(input phase_e ph, input logic r, input logic [5:0] op,
                      input logic rdy, input logic z, input logic le,
                      input logic [15:0] lv, input string nm);
    @(posedge clk);
    #1;
    rst = r; opcode = op; mem_ready = rdy; zero = z;
    exp_w = r ? 16'h0000 : model(ph, rdy, z);
    chk_v = 1'b1; lit_v = le; lit_w = lv; chk_name = nm;
  endtask

  // Phase sequence per instruction class, with optional wait cycles.
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input logic z);
    for (int i = 0; i < fw; i++) step(P_FETCH, 0, op, 0, rb(), 1, 16'h2020, "fetch_wait");
    step(P_FETCH, 0, op, 1, rb(), 1, 16'hA820, "fetch");
    step(P_DECODE, 0, op, rb(), rb(), 0, 16'h0, "decode");
    case (op)
      6'b100011: begin
        step(P_MEMADR, 0, op, rb(), rb(), 0, 16'h0, "lw_adr");
        for (int i = 0; i < mw; i++) step(P_MEMRD, 0, op, 0, rb(), 1, 16'h6000, "lw_rd_wait");
        step(P_MEMRD, 0, op, 1, rb(), 1, 16'h6000, "lw_rd");
        step(P_MEMWB, 0, op, rb(), rb(), 1, 16'h0300, "lw_wb");
      end
      6'b101011: begin
        step(P_MEMADR, 0, op, rb(), rb(), 0, 16'h0, "sw_adr");
        for (int i = 0; i < mw; i++) step(P_MEMWR, 0, op, 0, rb(), 1, 16'h5000, "sw_wr_wait");
        step(P_MEMWR, 0, op, 1, rb(), 1, 16'h5000, "sw_wr");
      end
      6'b000000: begin
        step(P_REX, 0, op, rb(), rb(), 0, 16'h0, "r_ex");
        step(P_RWB, 0, op, rb(), rb(), 1, 16'h0500, "r_wb");
      end
      6'b001000: begin
        step(P_AEX, 0, op, rb(), rb(), 1, 16'h00C0, "addi_ex");
        step(P_AWB, 0, op, rb(), rb(), 1, 16'h0100, "addi_wb");
      end
      6'b000100: step(P_BR, 0, op, rb(), z, 1, z ? 16'h808A : 16'h008A, "beq");
      6'b000010: step(P_JUMP, 0, op, rb(), rb(), 1, 16'h8004, "jump");
`ifdef MC_CTRL_BNE_EN
      6'b000101: step(P_BNE, 0, op, rb(), z, 1, z ? 16'h008A : 16'h808A, "bne");
`endif
      default:   step(P_ILL, 0, op, rb(), rb(), 1, 16'h0001, "illegal");
    endcase
  endtask

  initial begin
    step(P_ZERO, 1, 6'd0, 1, 1, 1, 16'h0000, "reset0");
    step(P_ZERO, 1, 6'd0, 1, 1, 1, 16'h0000, "reset1");
    step(P_ZERO, 0, 6'd0, 1, 1, 1, 16'h0000, "idle");

    run_instr(6'b100011, 0, 0, 1'b0);
    run_instr(6'b101011, 1, 3, 1'b0);
    run_instr(6'b000000, 0, 0, 1'b0);
    run_instr(6'b001000, 0, 0, 1'b0);
    run_instr(6'b000100, 0, 0, 1'b1);
    run_instr(6'b000100, 2, 0, 1'b0);
    run_instr(6'b000010, 0, 0, 1'b0);
    run_instr(6'b111111, 0, 0, 1'b0);
    run_instr(6'b000101, 0, 0, 1'b0);
    run_instr(6'b000101, 0, 0, 1'b1);
    run_instr(6'b010101, 1, 0, 1'b0);

    // Abort a load while it waits on memory.
    step(P_FETCH, 0, 6'b100011, 1, 0, 1, 16'hA820, "abort_fetch");
    step(P_DECODE, 0, 6'b100011, 0, 0, 0, 16'h0, "abort_decode");
    step(P_MEMADR, 0, 6'b100011, 0, 0, 0, 16'h0, "abort_adr");
    step(P_MEMRD, 0, 6'b100011, 0, 0, 1, 16'h6000, "abort_rd_wait");
    step(P_MEMRD, 0, 6'b100011, 0, 0, 1, 16'h6000, "abort_rd_wait");
    step(P_ZERO, 1, 6'b100011, 1, 0, 1, 16'h0000, "abort_rst");
    step(P_ZERO, 0, 6'b100011, 1, 0, 1, 16'h0000, "abort_idle");
    run_instr(6'b100011, 0, 1, 1'b0);

    @(posedge clk);
    #1;
    chk_v = 1'b0;
    lit_v = 1'b0;
    @(negedge clk);
    #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
